// File: rtl/torus_vc_buffered_switch.sv
// Buffered 3-in/3-out router node for a unidirectional 2-D torus: input FIFOs, X-first routing,
// round-robin output arbitration. Define TORUS_SW_STATS_EN to add saturating per-output forward counters.
module torus_vc_buffered_switch #(
    parameter int X           = 2,
    parameter int Y           = 2,
    parameter int x_coord     = 0,
    parameter int y_coord     = 0,
    parameter int data_width  = 32,
    parameter int x_size      = 1,
    parameter int y_size      = 1,
    parameter int total_width = x_size + y_size + data_width,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   i_valid_l,
    input  logic                   i_valid_b,
    input  logic                   i_valid_pe,
    input  logic [total_width-1:0] i_data_l,
    input  logic [total_width-1:0] i_data_b,
    input  logic [total_width-1:0] i_data_pe,
    output logic                   o_ready_l,
    output logic                   o_ready_b,
    output logic                   o_ready_pe,
    output logic                   o_valid_r,
    output logic                   o_valid_t,
    output logic                   o_valid_pe,
    output logic [total_width-1:0] o_data_r,
    output logic [total_width-1:0] o_data_t,
    output logic [total_width-1:0] o_data_pe,
`ifdef TORUS_SW_STATS_EN
    output logic [47:0]            o_fwd_count,
`endif
    input  logic                   i_ready_r,
    input  logic                   i_ready_t,
    input  logic                   i_ready_pe
);

    localparam int NP = 3;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0]     DEPTH_P = PW'(FIFO_DEPTH);
    localparam logic [x_size-1:0] MY_X    = x_size'(x_coord % X);
    localparam logic [y_size-1:0] MY_Y    = y_size'(y_coord % Y);

    typedef logic [total_width-1:0] flit_t;
    typedef enum logic [1:0] {P_RIGHT = 2'd0, P_TOP = 2'd1, P_PE = 2'd2} out_sel_e;

    // Inputs indexed l=0, b=1, pe=2; outputs indexed right=0, top=1, pe=2.
    logic [NP-1:0] in_valid, in_ready, push, pop, has_head, out_ready;
    flit_t         in_data [NP];
    flit_t         head    [NP];
    out_sel_e      route   [NP];

    logic [NP-1:0] out_valid_q, out_valid_d;
    flit_t         out_data_q [NP];
    flit_t         out_data_d [NP];
    logic [1:0]    prio_q     [NP];
    logic [1:0]    prio_d     [NP];

    assign in_valid   = {i_valid_pe, i_valid_b, i_valid_l};
    assign in_data[0] = i_data_l;
    assign in_data[1] = i_data_b;
    assign in_data[2] = i_data_pe;
    assign out_ready  = {i_ready_pe, i_ready_t, i_ready_r};
    assign push       = in_valid & in_ready;

    assign {o_ready_pe, o_ready_b, o_ready_l} = in_ready;

    for (genvar g = 0; g < NP; g++) begin : g_fifo
        flit_t             mem_q [FIFO_DEPTH];
        logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
        logic [x_size-1:0] dest_x;
        logic [y_size-1:0] dest_y;

        // NOTE: the storage array is deliberately left out of reset; the pointers alone
        // define which entries are live, so an unreset RAM is both correct and cheaper.
        always_ff @(posedge clk) begin
            if (push[g]) mem_q[wr_ptr_q[AW-1:0]] <= in_data[g];
        end

        assign wr_ptr_d = push[g] ? wr_ptr_q + PW'(1) : wr_ptr_q;
        assign rd_ptr_d = pop[g]  ? rd_ptr_q + PW'(1) : rd_ptr_q;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
            end
        end

        // Ready is a function of the registered count only, never of this cycle's pop.
        assign count       = wr_ptr_q - rd_ptr_q;
        assign in_ready[g] = (count != DEPTH_P);
        assign has_head[g] = (count != '0);
        assign head[g]     = mem_q[rd_ptr_q[AW-1:0]];

        assign dest_y   = head[g][total_width-1 -: y_size];
        assign dest_x   = head[g][total_width-y_size-1 -: x_size];
        assign route[g] = (dest_x != MY_X) ? P_RIGHT :
                          (dest_y != MY_Y) ? P_TOP   : P_PE;
    end

    // Per output: round-robin starting at prio_q, only when the output register can accept.
    always_comb begin
        logic [1:0] idx;
        logic       done;
        // NOTE: every signal written here gets a default before any branch, so no path
        // leaves a value unassigned and no latch can be inferred.
        idx  = '0;
        done = 1'b0;
        pop  = '0;
        for (int o = 0; o < NP; o++) begin
            out_valid_d[o] = out_valid_q[o] & ~out_ready[o];
            out_data_d[o]  = out_data_q[o];
            prio_d[o]      = prio_q[o];
        end
        for (int o = 0; o < NP; o++) begin
            done = 1'b0;
            if (!out_valid_q[o] || out_ready[o]) begin
                for (int k = 0; k < NP; k++) begin
                    idx = 2'((int'(prio_q[o]) + k) % NP);
                    if (!done && has_head[idx] && route[idx] == out_sel_e'(o)) begin
                        done           = 1'b1;
                        pop[idx]       = 1'b1;
                        out_valid_d[o] = 1'b1;
                        out_data_d[o]  = head[idx];
                        prio_d[o]      = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_q <= '0;
            for (int o = 0; o < NP; o++) begin
                out_data_q[o] <= '0;
                prio_q[o]     <= '0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            for (int o = 0; o < NP; o++) begin
                out_data_q[o] <= out_data_d[o];
                prio_q[o]     <= prio_d[o];
            end
        end
    end

    assign o_valid_r  = out_valid_q[0];
    assign o_valid_t  = out_valid_q[1];
    assign o_valid_pe = out_valid_q[2];
    assign o_data_r   = out_data_q[0];
    assign o_data_t   = out_data_q[1];
    assign o_data_pe  = out_data_q[2];

`ifdef TORUS_SW_STATS_EN
    logic [15:0] fwd_cnt_q [NP];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int o = 0; o < NP; o++) fwd_cnt_q[o] <= '0;
        end else begin
            for (int o = 0; o < NP; o++) begin
                if (out_valid_q[o] && out_ready[o] && fwd_cnt_q[o] != 16'hFFFF)
                    fwd_cnt_q[o] <= fwd_cnt_q[o] + 16'd1;
            end
        end
    end

    assign o_fwd_count = {fwd_cnt_q[2], fwd_cnt_q[1], fwd_cnt_q[0]};
`endif

endmodule

// File: tb/tb_torus_vc_buffered_switch.sv
// Self-checking bench for torus_vc_buffered_switch (node 0,0 of a 2x2 torus, FIFO_DEPTH=4):
// routing vector table, directed corner sequences, and a randomized run against a queue-based scoreboard.
`timescale 1ns/1ps
module tb_torus_vc_buffered_switch;

    localparam int TW = 34;
    typedef logic [TW-1:0] flit_t;

    typedef struct {
        int          src;
        int          dx;
        int          dy;
        logic [31:0] pl;
        int          out;
        logic [2:0]  exp_vld;
    } vec_t;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic [2:0] i_vld, rdy, o_rdy, o_vld;
    flit_t      i_dat [3];
    flit_t      o_dat [3];
`ifdef TORUS_SW_STATS_EN
    logic [47:0] fwd_count;
`endif

    int    n_cmp = 0;
    int    n_fail = 0;
    flit_t drv_q [3][$];
    flit_t exp_q [9][$];
    int    acc_cnt [3];
    bit    mon_en = 1'b0;
    logic [2:0] hold = '0;
    flit_t      hold_dat [3];

    always #5 clk = ~clk;

    torus_vc_buffered_switch #(
        .X(2), .Y(2), .x_coord(0), .y_coord(0), .data_width(32),
        .x_size(1), .y_size(1), .total_width(TW), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rstn(rstn),
        .i_valid_l(i_vld[0]), .i_valid_b(i_vld[1]), .i_valid_pe(i_vld[2]),
        .i_data_l(i_dat[0]), .i_data_b(i_dat[1]), .i_data_pe(i_dat[2]),
        .o_ready_l(o_rdy[0]), .o_ready_b(o_rdy[1]), .o_ready_pe(o_rdy[2]),
        .o_valid_r(o_vld[0]), .o_valid_t(o_vld[1]), .o_valid_pe(o_vld[2]),
        .o_data_r(o_dat[0]), .o_data_t(o_dat[1]), .o_data_pe(o_dat[2]),
`ifdef TORUS_SW_STATS_EN
        .o_fwd_count(fwd_count),
`endif
        .i_ready_r(rdy[0]), .i_ready_t(rdy[1]), .i_ready_pe(rdy[2])
    );

    function automatic flit_t mk(int dx, int dy, logic [31:0] pl);
        return {dy[0], dx[0], pl};
    endfunction

    // X-first dimension-order routing for node (0,0): 0=right, 1=top, 2=pe.
    function automatic int route_of(flit_t f);
        if (f[32] != 1'b0) return 0;
        if (f[33] != 1'b0) return 1;
        return 2;
    endfunction

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic present();
        for (int i = 0; i < 3; i++) begin
            if (drv_q[i].size() > 0) begin
                i_vld[i] = 1'b1;
                i_dat[i] = drv_q[i][0];
            end else begin
                i_vld[i] = 1'b0;
                i_dat[i] = '0;
            end
        end
    endtask

    // One clock: producers hold each flit until it is accepted.
    task automatic tick();
        logic [2:0] acc;
        present();
        acc = i_vld & o_rdy;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (acc[i]) begin
                acc_cnt[i]++;
                if (mon_en) exp_q[i*3 + route_of(drv_q[i][0])].push_back(drv_q[i][0]);
                void'(drv_q[i].pop_front());
            end
        end
        present();
    endtask

    task automatic do_reset();
        #2 rstn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drv_q[i].delete();
            acc_cnt[i] = 0;
        end
        present();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: each output transfer must be the oldest outstanding flit of its (source, output) pair.
    always @(negedge clk) begin : mon
        int s;
        int q;
        for (int o = 0; o < 3; o++) begin
            if (mon_en) begin
                if (hold[o]) begin
                    check("hold_valid", o_vld[o], 1);
                    check("hold_data", o_dat[o], hold_dat[o]);
                end
                if (o_vld[o] && rdy[o]) begin
                    s = int'(o_dat[o][31:30]);
                    check("out_src_tag", s < 3, 1);
                    if (s < 3) begin
                        q = s*3 + o;
                        check("sb_has_flit", exp_q[q].size() != 0, 1);
                        if (exp_q[q].size() != 0) begin
                            check("sb_order", o_dat[o], exp_q[q][0]);
                            void'(exp_q[q].pop_front());
                        end
                    end
                end
                hold[o]     = o_vld[o] && !rdy[o];
                hold_dat[o] = o_dat[o];
            end else begin
                hold[o] = 1'b0;
            end
        end
    end

    initial begin
        vec_t  vecs [8];
        flit_t got [$];
        flit_t f;
        logic [2:0] seen;
        int    seq;
        bit    pending;

        vecs[0] = '{2, 1, 0, 32'hA5A5A5A5, 0, 3'b001};
        vecs[1] = '{0, 0, 1, 32'h11111111, 1, 3'b010};
        vecs[2] = '{1, 0, 0, 32'h22222222, 2, 3'b100};
        vecs[3] = '{0, 1, 1, 32'h33333333, 0, 3'b001};
        vecs[4] = '{1, 1, 0, 32'h44444444, 0, 3'b001};
        vecs[5] = '{2, 0, 1, 32'h55555555, 1, 3'b010};
        vecs[6] = '{2, 0, 0, 32'h66666666, 2, 3'b100};
        vecs[7] = '{1, 1, 1, 32'h77777777, 0, 3'b001};

        i_vld = '0;
        rdy   = 3'b111;
        for (int i = 0; i < 3; i++) begin
            i_dat[i]   = '0;
            acc_cnt[i] = 0;
        end

        // Reset state
        #13;
        check("rst_valid", o_vld, 3'b000);
        check("rst_data_r", o_dat[0], 0);
        check("rst_data_t", o_dat[1], 0);
        check("rst_data_pe", o_dat[2], 0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ready", o_rdy, 3'b111);

        // Single-flit routing and 2-cycle latency table
        for (int v = 0; v < 8; v++) begin
            f = mk(vecs[v].dx, vecs[v].dy, vecs[v].pl);
            drv_q[vecs[v].src].push_back(f);
            acc_cnt[vecs[v].src] = 0;
            tick();
            check("vec_accepted", acc_cnt[vecs[v].src], 1);
            check("vec_not_yet", o_vld, 3'b000);
            tick();
            check("vec_valid", o_vld, vecs[v].exp_vld);
            check("vec_data", o_dat[vecs[v].out], f);
            tick();
        end

        // Left->top and bottom->pe in the same cycle
        drv_q[0].push_back(mk(0, 1, 32'hAAAA0001));
        drv_q[1].push_back(mk(0, 0, 32'hBBBB0002));
        tick();
        tick();
        check("pair_valid", o_vld, 3'b110);
        check("pair_top", o_dat[1], mk(0, 1, 32'hAAAA0001));
        check("pair_pe", o_dat[2], mk(0, 0, 32'hBBBB0002));
        tick();

        // Round-robin: l and pe contend for right; first grant after reset goes to l
        do_reset();
        for (int n = 0; n < 6; n++) begin
            drv_q[0].push_back(mk(1, 0, 32'h1000 + n));
            drv_q[2].push_back(mk(1, 0, 32'h2000 + n));
        end
        got.delete();
        for (int c = 0; c < 30; c++) begin
            if (o_vld[0]) got.push_back(o_dat[0]);
            tick();
        end
        check("rr_count", got.size(), 12);
        for (int n = 0; n < 12 && n < got.size(); n++) begin
            f = mk(1, 0, ((n % 2) == 0 ? 32'h1000 : 32'h2000) + n / 2);
            check("rr_order", got[n], f);
        end

        // Backpressure: right stalled, left streams 6 flits
        do_reset();
        rdy[0] = 1'b0;
        for (int n = 1; n <= 6; n++) drv_q[0].push_back(mk(1, 0, n));
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 4) check("bp_ready_before_full", o_rdy[0], 1);
            if (c == 5) check("bp_ready_low_full", o_rdy[0], 0);
        end
        check("bp_accepted", acc_cnt[0], 5);
        check("bp_ready_still_low", o_rdy[0], 0);
        check("bp_out_valid", o_vld[0], 1);
        check("bp_out_held", o_dat[0], mk(1, 0, 1));
        rdy[0] = 1'b1;
        got.delete();
        for (int c = 0; c < 15; c++) begin
            if (o_vld[0]) got.push_back(o_dat[0]);
            tick();
        end
        check("bp_drain_count", got.size(), 6);
        for (int n = 0; n < 6 && n < got.size(); n++) check("bp_drain_order", got[n], mk(1, 0, n + 1));
        check("bp_ready_back", o_rdy[0], 1);
        check("bp_all_accepted", acc_cnt[0], 6);

        // Reset mid-operation with buffered flits
        rdy[0] = 1'b0;
        for (int n = 0; n < 3; n++) drv_q[0].push_back(mk(1, 0, 32'hDEAD0000 + n));
        repeat (4) tick();
        check("mid_rst_pre_valid", o_vld[0], 1);
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_valid_low", o_vld, 3'b000);
        check("mid_rst_data_zero", o_dat[0], 0);
        for (int i = 0; i < 3; i++) drv_q[i].delete();
        present();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_ready", o_rdy, 3'b111);
        rdy  = 3'b111;
        seen = '0;
        repeat (6) begin
            tick();
            seen = seen | o_vld;
        end
        check("mid_rst_no_stale", seen, 3'b000);

        // Randomized traffic against the scoreboard
        do_reset();
        for (int q = 0; q < 9; q++) exp_q[q].delete();
        mon_en = 1'b1;
        seq    = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (drv_q[i].size() < 2 && $urandom_range(0, 2) != 0) begin
                    drv_q[i].push_back(mk(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                                          {i[1:0], seq[29:0]}));
                    seq++;
                end
            end
            for (int o = 0; o < 3; o++) rdy[o] = ($urandom_range(0, 3) != 0);
            tick();
        end
        rdy     = 3'b111;
        pending = 1'b1;
        for (int c = 0; c < 200 && pending; c++) begin
            tick();
            pending = 1'b0;
            for (int i = 0; i < 3; i++) if (drv_q[i].size() != 0) pending = 1'b1;
            for (int q = 0; q < 9; q++) if (exp_q[q].size() != 0) pending = 1'b1;
        end
        check("rand_drained", pending, 0);
        check("rand_outputs_idle", o_vld, 3'b000);
        mon_en = 1'b0;

`ifdef TORUS_SW_STATS_EN
        do_reset();
        check("stats_reset", fwd_count, 48'd0);
        for (int n = 0; n < 3; n++) drv_q[1].push_back(mk(0, 0, n));
        for (int n = 0; n < 2; n++) drv_q[0].push_back(mk(1, 0, n));
        repeat (10) tick();
        check("stats_count", fwd_count, {16'd3, 16'd0, 16'd2});
        i_vld[0] = 1'b1;
        i_dat[0] = mk(1, 0, 32'h7);
        repeat (65545) @(posedge clk);
        #1;
        i_vld[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("stats_saturate", fwd_count, {16'd3, 16'd0, 16'hFFFF});
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
